// File: rtl/ahb_lite_timer.sv
// AHB-Lite timer slave: zero-wait-state register block with a 32-bit
// prescaled down-counter, auto-reload or one-shot mode, sticky flag and IRQ.
module ahb_lite_timer #(
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [3:0]  HPROT,
  input  logic [2:0]  HSIZE,
  input  logic [1:0]  HTRANS,
  input  logic [31:0] HWDATA,
  input  logic        HWRITE,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic        IRQ
);

  localparam logic [2:0] OFS_CTRL     = 3'd0;
  localparam logic [2:0] OFS_LOAD     = 3'd1;
  localparam logic [2:0] OFS_VALUE    = 3'd2;
  localparam logic [2:0] OFS_PRESCALE = 3'd3;
  localparam logic [2:0] OFS_STATUS   = 3'd4;

  logic                      dp_valid;
  logic [2:0]                dp_addr;
  logic                      dp_write;
  logic                      dp_word;

  logic                      ctrl_en;
  logic                      ctrl_ie;
  logic                      ctrl_oneshot;
  logic [31:0]               load_reg;
  logic [31:0]               value_reg;
  logic [PRESCALE_WIDTH-1:0] prescale_reg;
  logic [PRESCALE_WIDTH-1:0] presc_cnt;
  logic                      if_flag;

  logic                      accept;
  logic                      wr_word;
  logic                      wr_ctrl;
  logic                      wr_load;
  logic                      wr_prescale;
  logic                      wr_status;
  logic                      tick;
  logic                      reload;
  logic                      en_rise;
  logic [31:0]               rd_mux;
  logic                      unused_bits;

  assign accept      = HSEL & HTRANS[1] & HREADY;
  assign wr_word     = dp_valid & dp_write & dp_word;
  assign wr_ctrl     = wr_word & (dp_addr == OFS_CTRL);
  assign wr_load     = wr_word & (dp_addr == OFS_LOAD);
  assign wr_prescale = wr_word & (dp_addr == OFS_PRESCALE);
  assign wr_status   = wr_word & (dp_addr == OFS_STATUS);

  assign tick    = ctrl_en & (presc_cnt == prescale_reg);
  // A LOAD write in the same cycle swallows the tick entirely.
  assign reload  = tick & (value_reg == 32'd0) & ~wr_load;
  assign en_rise = wr_ctrl & HWDATA[0] & ~ctrl_en;

  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  assign IRQ       = if_flag & ctrl_ie;

  assign unused_bits = ^{HPROT, HADDR[31:5], HADDR[1:0], HTRANS[0]};

  // Address-phase capture; registers hold when no transfer is accepted.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dp_valid <= 1'b0;
      dp_addr  <= 3'd0;
      dp_write <= 1'b0;
      dp_word  <= 1'b0;
    end else if (accept) begin
      dp_valid <= 1'b1;
      dp_addr  <= HADDR[4:2];
      dp_write <= HWRITE;
      dp_word  <= (HSIZE == 3'b010);
    end else begin
      dp_valid <= 1'b0;
    end
  end

  // Register writes, prescaler, down-counter and sticky flag.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      ctrl_en      <= 1'b0;
      ctrl_ie      <= 1'b0;
      ctrl_oneshot <= 1'b0;
      load_reg     <= 32'd0;
      value_reg    <= 32'd0;
      prescale_reg <= '0;
      presc_cnt    <= '0;
      if_flag      <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ctrl_en      <= HWDATA[0];
        ctrl_ie      <= HWDATA[1];
        ctrl_oneshot <= HWDATA[2];
      end else if (reload && ctrl_oneshot) begin
        ctrl_en <= 1'b0;
      end

      if (wr_load) begin
        load_reg <= HWDATA;
      end

      if (wr_prescale) begin
        prescale_reg <= HWDATA[PRESCALE_WIDTH-1:0];
      end

      if (wr_load || en_rise) begin
        presc_cnt <= '0;
      end else if (ctrl_en) begin
        presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
      end

      if (wr_load) begin
        value_reg <= HWDATA;
      end else if (tick) begin
        value_reg <= (value_reg == 32'd0) ? load_reg : value_reg - 32'd1;
      end

      if (reload) begin
        if_flag <= 1'b1;
      end else if (wr_status && HWDATA[0]) begin
        if_flag <= 1'b0;
      end
    end
  end

  // Read mux for the offset latched in the address phase.
  always_comb begin
    rd_mux = 32'd0;
    case (dp_addr)
      OFS_CTRL:     rd_mux[2:0] = {ctrl_oneshot, ctrl_ie, ctrl_en};
      OFS_LOAD:     rd_mux = load_reg;
      OFS_VALUE:    rd_mux = value_reg;
      OFS_PRESCALE: rd_mux[PRESCALE_WIDTH-1:0] = prescale_reg;
      OFS_STATUS:   rd_mux[0] = if_flag;
      default:      rd_mux = 32'd0;
    endcase
  end

  // Read data only while a read occupies the data phase.
  always_comb begin
    HRDATA = 32'd0;
    if (dp_valid && !dp_write) begin
      HRDATA = rd_mux;
    end
  end

endmodule

// File: doc/ahb_lite_timer.md
Name: ahb_lite_timer

Overview:
- Zero-wait-state AHB-Lite slave that sits on one decoder select and slave-mux return slot of the AHB-Lite interconnect, beside the RAM/GPIO/UART/HDMI slaves.
- Provides a 32-bit prescaled down-counter with auto-reload or one-shot mode, sticky interrupt flag and level IRQ output.
- Consumes address/data phases from the bus. Returns HRDATA, HREADYOUT and HRESP to the slave mux.

Parameters:
- PRESCALE_WIDTH, 16, width of the PRESCALE register and the internal prescale counter (1..32).

Ports:
- HCLK  in  1  bus clock, all logic rising-edge.
- HRESET  in  1  synchronous active-high reset.
- HSEL  in  1  slave select from decoder.
- HADDR  in  32  address; only HADDR[4:2] decoded.
- HPROT  in  4  ignored.
- HSIZE  in  3  transfer size.
- HTRANS  in  2  transfer type.
- HWDATA  in  32  write data (data phase).
- HWRITE  in  1  1 = write.
- HREADY  in  1  bus-wide ready from slave mux.
- HRDATA  out  32  read data.
- HREADYOUT  out  1  always 1.
- HRESP  out  1  always 0 (OKAY).
- IRQ  out  1  interrupt, level.

Behaviour:
- Clock and reset: one clock, HCLK. HRESET is synchronous and active-high.
- Reset values:
  - CTRL=0, LOAD=0, VALUE=0, PRESCALE=0, IF=0, prescale counter=0, address-phase regs cleared.
  - Outputs: HRDATA=0, IRQ=0, HREADYOUT=1, HRESP=0.
- Address phase:
  - Accepted when HSEL & HTRANS[1] & HREADY.
  - Register on that edge: valid flag, HADDR[4:2], HWRITE, and word flag = (HSIZE==3'b010).
  - Otherwise the valid flag clears. An IDLE/BUSY transfer or HSEL=0 leaves registers untouched.
- Data phase:
  - Write commits at the end of the data-phase cycle using HWDATA.
  - Sub-word writes (word flag 0) are ignored with OKAY.
  - Read: HRDATA is combinational from the latched offset during the data phase. It is 0 when no read is in the data phase.
- Register map (offset, access):
  - 0x00 CTRL RW: bit0 EN, bit1 IE, bit2 ONESHOT; other bits read 0.
  - 0x04 LOAD RW: 32-bit reload value.
  - 0x08 VALUE RO: current count; writes ignored.
  - 0x0C PRESCALE RW: [PRESCALE_WIDTH-1:0]; upper bits read 0.
  - 0x10 STATUS: bit0 IF. Write 1 clears, write 0 has no effect.
  - 0x14–0x1C: read 0, writes ignored.
- Side effects of writes:
  - Writing LOAD also sets VALUE←written value and clears the prescale counter in the same commit.
  - Writing CTRL with EN 0→1 clears the prescale counter. VALUE is kept.
- Counting, when EN=1:
  - Prescale counter increments each cycle.
  - When the counter equals PRESCALE it wraps to 0 and generates tick.
  - On tick with VALUE≠0: VALUE←VALUE−1.
  - On tick with VALUE==0: IF←1 and VALUE←LOAD; if ONESHOT=1, EN←0 in the same edge.
  - Period = (LOAD+1)×(PRESCALE+1) cycles. LOAD=0 with PRESCALE=0 sets IF every cycle.
- EN=0: counter and VALUE frozen.
- IRQ = IF & IE, driven from registers with no combinational path from the bus.
- Simultaneous events:
  - Hardware IF set wins over a same-cycle STATUS clear.
  - A LOAD write wins over a same-cycle tick (VALUE←written value, no decrement, IF unchanged by that tick).
  - A CTRL write clearing EN wins over the ONESHOT auto-clear (result EN=0 either way).
- Back-to-back transfers: a write data phase overlapping the next address phase is fully supported. A read immediately after a write to the same register returns the new value.
- Reset mid-operation: HRESET asserted in any cycle, including a data phase, returns all state to reset values on that edge. The pending write is dropped.

Test Plan:
- Reset then read all offsets 0x00–0x1C -> all read 0x00000000, HREADYOUT=1, HRESP=0 throughout.
- Write LOAD=3, PRESCALE=0, CTRL=0x3 (commit edge E) -> VALUE reads 3,2,1,0 on edges E+1..E+3. IF and IRQ rise at E+4 with VALUE=3. IF repeats every 4 cycles.
- PRESCALE=4, LOAD=1, ONESHOT|EN -> IF set after exactly 10 cycles. CTRL then reads EN=0, and VALUE=1 stays frozen.
- With IF=1, write STATUS=0x1 in a cycle where a tick also sets IF -> IF remains 1. A subsequent clear with no tick -> IF=0, IRQ=0.
- Byte write (HSIZE=000) of 0xFF to LOAD, then word read -> LOAD unchanged. Write to 0x08 -> VALUE unaffected. IDLE transfer with HSEL=1 -> no register change.
- Assert HRESET during the data phase of a LOAD=0x1234 write -> LOAD reads 0 after reset and IRQ=0.
